// File: rtl/tlb_arb_pkg.sv
// tlb_arb_pkg: shared types and constants for the TLB port arbiter.
//   state_e          - sequencer states (idle, access in flight, one-cycle gap)
//   owner_e          - which requester owns the current access
//   err_e / ErrW     - completion code returned with done
//   DefTimeoutCycles - default abort limit when TLB_ARB_TIMEOUT_EN is defined
package tlb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int unsigned ErrW = 2;

  typedef enum logic [ErrW-1:0] {
    ErrOk         = 2'd0,
    ErrNotPresent = 2'd1,
    ErrNotUser    = 2'd2,
    ErrTimeout    = 2'd3
  } err_e;

  localparam int unsigned DefTimeoutCycles = 64;

endpackage

// File: rtl/tlb_rr_pick2.sv
// tlb_rr_pick2: combinational two-input round-robin select.
//   req  in  2  request vector, bit 0 = master 0, bit 1 = master 1
//   last in  1  index of the master granted most recently
//   any  out 1  at least one request present
//   pick out 1  index of the winning master (meaningful only when any = 1)
module tlb_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       pick
);

  assign any  = |req;
  // On a tie the master not granted last wins; otherwise the sole requester wins.
  assign pick = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/tlb_port_arbiter.sv
// tlb_port_arbiter: shares the TLB CPU-side port between instruction fetch (IF)
// and load/store (LS). One access at a time: arbitrate, drive the TLB strobes
// from latched request fields, wait for completion or fault, return the result
// to the owner, then hold the strobes low for one cycle before the next grant.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_is_user                    privilege, latched at grant
//   i_if_req, i_if_address       fetch request (read-only)
//   o_if_valid/done/error/rdata  fetch result (valid/done are 1-cycle pulses)
//   i_ls_req/write/address/wdata load/store request
//   o_ls_valid/done/error/rdata  load/store result
//   o_tlb_*                      registered TLB request fields and strobes
//   i_tlb_rdata/valid/error_*    TLB response
//
// Build option: define TLB_ARB_TIMEOUT_EN to abort an access with code 3 after
// TIMEOUT_CYCLES busy cycles without a response. Without it BUSY waits forever.
module tlb_port_arbiter import tlb_arb_pkg::*; #(
`ifdef TLB_ARB_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
`endif
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_is_user,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_address,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic [ErrW-1:0]   o_if_error,
  output logic              o_if_done,
  input  logic              i_ls_req,
  input  logic              i_ls_write,
  input  logic [ADDR_W-1:0] i_ls_address,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_valid,
  output logic              o_ls_done,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic [ErrW-1:0]   o_ls_error,
  output logic [ADDR_W-1:0] o_tlb_address,
  output logic              o_tlb_read,
  output logic              o_tlb_write,
  output logic              o_tlb_is_user,
  output logic [DATA_W-1:0] o_tlb_wdata,
  input  logic [DATA_W-1:0] i_tlb_rdata,
  input  logic              i_tlb_valid,
  input  logic              i_tlb_error_not_present,
  input  logic              i_tlb_error_not_user
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              user_q, user_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              if_valid_q, if_valid_d, if_done_q, if_done_d;
  logic              ls_valid_q, ls_valid_d, ls_done_q, ls_done_d;
  err_e              if_err_q, if_err_d, ls_err_q, ls_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

  logic any_req, pick_ls;
  logic hit;
  err_e code;

`ifdef TLB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  tlb_rr_pick2 u_pick (
    .req  ({i_ls_req, i_if_req}),
    .last (last_q == OWN_LS),
    .any  (any_req),
    .pick (pick_ls)
  );

  // Completion decode in priority order; a real TLB response outranks the timeout.
  always_comb begin
    hit  = 1'b1;
    code = ErrOk;
    if (i_tlb_error_not_user) begin
      code = ErrNotUser;
    end else if (i_tlb_error_not_present) begin
      code = ErrNotPresent;
    end else if (i_tlb_valid) begin
      code = ErrOk;
`ifdef TLB_ARB_TIMEOUT_EN
    end else if (cnt_q == CntMax) begin
      code = ErrTimeout;
`endif
    end else begin
      hit = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    user_d     = user_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if_err_d   = if_err_q;
    ls_err_d   = ls_err_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_valid_d = 1'b0;
    if_done_d  = 1'b0;
    ls_valid_d = 1'b0;
    ls_done_d  = 1'b0;
`ifdef TLB_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (any_req) begin
          user_d = i_is_user;
          if (pick_ls) begin
            owner_d = OWN_LS;
            last_d  = OWN_LS;
            addr_d  = i_ls_address;
            wdata_d = i_ls_wdata;
            write_d = i_ls_write;
            rd_d    = ~i_ls_write;
            wr_d    = i_ls_write;
          end else begin
            // Fetch is read-only.
            owner_d = OWN_IF;
            last_d  = OWN_IF;
            addr_d  = i_if_address;
            wdata_d = '0;
            write_d = 1'b0;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
          end
`ifdef TLB_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          state_d = StBusy;
        end
      end

      StBusy: begin
        if (hit) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StDone;
          if (owner_q == OWN_LS) begin
            ls_done_d  = 1'b1;
            ls_err_d   = code;
            ls_valid_d = (code == ErrOk);
            if (code == ErrOk) ls_rdata_d = i_tlb_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_err_d   = code;
            if_valid_d = (code == ErrOk);
            if (code == ErrOk) if_rdata_d = i_tlb_rdata;
          end
        end else begin
`ifdef TLB_ARB_TIMEOUT_EN
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end

      // One idle-strobe cycle so the owner can drop req; requests are ignored.
      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      owner_q    <= OWN_IF;
      last_q     <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      user_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      if_valid_q <= 1'b0;
      if_done_q  <= 1'b0;
      ls_valid_q <= 1'b0;
      ls_done_q  <= 1'b0;
      if_err_q   <= ErrOk;
      ls_err_q   <= ErrOk;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
`ifdef TLB_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      user_q     <= user_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if_valid_q <= if_valid_d;
      if_done_q  <= if_done_d;
      ls_valid_q <= ls_valid_d;
      ls_done_q  <= ls_done_d;
      if_err_q   <= if_err_d;
      ls_err_q   <= ls_err_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
`ifdef TLB_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign o_if_valid    = if_valid_q;
  assign o_if_done     = if_done_q;
  assign o_if_error    = if_err_q;
  assign o_if_rdata    = if_rdata_q;
  assign o_ls_valid    = ls_valid_q;
  assign o_ls_done     = ls_done_q;
  assign o_ls_error    = ls_err_q;
  assign o_ls_rdata    = ls_rdata_q;
  assign o_tlb_address = addr_q;
  assign o_tlb_wdata   = wdata_q;
  assign o_tlb_is_user = user_q;
  assign o_tlb_read    = rd_q;
  assign o_tlb_write   = wr_q;

  // write_q documents the access kind; the strobes already encode it.
  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// tb_tlb_port_arbiter: directed scenarios with literal expectations, then a
// randomized run checked every cycle against a transaction-level model.
module tb_tlb_port_arbiter;

`ifdef TLB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 8;

  logic        clk, rst, is_user;
  logic        if_req, ls_req, ls_write;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        tlb_valid, tlb_np, tlb_nu;
  logic [31:0] tlb_rdata;
  logic        if_valid, if_done, ls_valid, ls_done;
  logic [1:0]  if_error, ls_error;
  logic [31:0] if_rdata, ls_rdata, tlb_addr, tlb_wdata;
  logic        tlb_read, tlb_write, tlb_user;

  tlb_port_arbiter #(
`ifdef TLB_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(TO),
`endif
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_is_user(is_user),
    .i_if_req(if_req), .i_if_address(if_addr),
    .o_if_valid(if_valid), .o_if_rdata(if_rdata), .o_if_error(if_error), .o_if_done(if_done),
    .i_ls_req(ls_req), .i_ls_write(ls_write), .i_ls_address(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_valid(ls_valid), .o_ls_done(ls_done), .o_ls_rdata(ls_rdata), .o_ls_error(ls_error),
    .o_tlb_address(tlb_addr), .o_tlb_read(tlb_read), .o_tlb_write(tlb_write),
    .o_tlb_is_user(tlb_user), .o_tlb_wdata(tlb_wdata),
    .i_tlb_rdata(tlb_rdata), .i_tlb_valid(tlb_valid),
    .i_tlb_error_not_present(tlb_np), .i_tlb_error_not_user(tlb_nu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one access in flight, a one-edge gap after each
  // completion, round-robin on ties. Port index 0 = fetch, 1 = load/store.
  bit          m_active, m_gap, m_write, m_user;
  int          m_owner, m_last, m_wait;
  logic [31:0] m_addr, m_wdata;
  bit          e_valid [2];
  bit          e_done  [2];
  logic [1:0]  e_err   [2];
  logic [31:0] e_rdata [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int code;
    int w;
    if (rst) begin
      m_active = 0; m_gap = 0; m_last = 0; m_wait = 0;
      for (int p = 0; p < 2; p++) begin
        e_valid[p] = 0; e_done[p] = 0; e_err[p] = 0; e_rdata[p] = 0;
      end
      return;
    end
    for (int p = 0; p < 2; p++) begin
      e_valid[p] = 0; e_done[p] = 0;
    end
    if (m_active) begin
      code = -1;
      if (tlb_nu) code = 2;
      else if (tlb_np) code = 1;
      else if (tlb_valid) code = 0;
      else if (TO_EN && m_wait == TO - 1) code = 3;
      if (code >= 0) begin
        e_done[m_owner] = 1;
        e_err[m_owner]  = 2'(code);
        if (code == 0) begin
          e_valid[m_owner] = 1;
          e_rdata[m_owner] = tlb_rdata;
        end
        m_active = 0;
        m_gap    = 1;
      end else begin
        m_wait++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (if_req || ls_req) begin
      if (if_req && ls_req) w = 1 - m_last;
      else w = ls_req ? 1 : 0;
      m_owner  = w;
      m_last   = w;
      m_user   = is_user;
      m_addr   = (w == 1) ? ls_addr : if_addr;
      m_write  = (w == 1) ? ls_write : 1'b0;
      m_wdata  = ls_wdata;
      m_active = 1;
      m_wait   = 0;
    end
  endtask

  task automatic compare_all();
    check("model if_valid", if_valid, e_valid[0]);
    check("model if_done", if_done, e_done[0]);
    check("model if_error", if_error, e_err[0]);
    check("model if_rdata", if_rdata, e_rdata[0]);
    check("model ls_valid", ls_valid, e_valid[1]);
    check("model ls_done", ls_done, e_done[1]);
    check("model ls_error", ls_error, e_err[1]);
    check("model ls_rdata", ls_rdata, e_rdata[1]);
    check("model tlb_read", tlb_read, m_active && !m_write);
    check("model tlb_write", tlb_write, m_active && m_write);
    if (m_active) begin
      check("model tlb_address", tlb_addr, m_addr);
      check("model tlb_is_user", tlb_user, m_user);
      if (m_write) check("model tlb_wdata", tlb_wdata, m_wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " if_valid"}, if_valid, 0);
    check({tag, " if_done"}, if_done, 0);
    check({tag, " if_error"}, if_error, 0);
    check({tag, " if_rdata"}, if_rdata, 0);
    check({tag, " ls_valid"}, ls_valid, 0);
    check({tag, " ls_done"}, ls_done, 0);
    check({tag, " ls_error"}, ls_error, 0);
    check({tag, " ls_rdata"}, ls_rdata, 0);
    check({tag, " tlb_read"}, tlb_read, 0);
    check({tag, " tlb_write"}, tlb_write, 0);
    check({tag, " tlb_address"}, tlb_addr, 0);
    check({tag, " tlb_wdata"}, tlb_wdata, 0);
    check({tag, " tlb_is_user"}, tlb_user, 0);
  endtask

  task automatic quiet_tlb();
    tlb_valid = 0; tlb_np = 0; tlb_nu = 0; tlb_rdata = 0;
  endtask

  initial begin
    bit seen;
    int cnt;
    rst = 1; is_user = 0; if_req = 0; ls_req = 0; ls_write = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
    quiet_tlb();

    // Reset state
    tick(); tick();
    check_quiet("reset");
    rst = 0;
    tick();

    // Fetch only, TLB answers two cycles after the strobe
    if_req = 1; if_addr = 32'h0040_1000;
    tick();
    check("fetch tlb_read", tlb_read, 1);
    check("fetch tlb_write", tlb_write, 0);
    check("fetch tlb_address", tlb_addr, 32'h0040_1000);
    tick();
    tlb_valid = 1; tlb_rdata = 32'hDEAD_BEEF;
    tick();
    check("fetch if_valid", if_valid, 1);
    check("fetch if_done", if_done, 1);
    check("fetch if_rdata", if_rdata, 32'hDEAD_BEEF);
    check("fetch if_error", if_error, 0);
    check("fetch ls_done quiet", ls_done, 0);
    check("fetch ls_valid quiet", ls_valid, 0);
    check("fetch strobe dropped", tlb_read, 0);
    if_req = 0; quiet_tlb();
    tick();
    check("fetch valid one cycle", if_valid, 0);
    check("fetch rdata held", if_rdata, 32'hDEAD_BEEF);

    // Tie after reset: LS first, then fetch
    rst = 1; tick(); rst = 0;
    if_req = 1; if_addr = 32'h0000_A000;
    ls_req = 1; ls_addr = 32'h0080_0000; ls_write = 0;
    tick();
    check("tie first grant ls", tlb_addr, 32'h0080_0000);
    tlb_valid = 1; tlb_rdata = 32'h1111_2222;
    tick();
    check("tie ls_done", ls_done, 1);
    check("tie done-cycle read low", tlb_read, 0);
    check("tie done-cycle write low", tlb_write, 0);
    ls_req = 0; quiet_tlb();
    tick();
    ls_req = 1;
    tick();
    check("tie second grant fetch", tlb_addr, 32'h0000_A000);
    tlb_valid = 1; tlb_rdata = 32'h3333_4444;
    tick();
    check("tie if_done", if_done, 1);
    check("tie if_rdata", if_rdata, 32'h3333_4444);
    if_req = 0; ls_req = 0; quiet_tlb();
    tick();

    // LS write, request fields stable until valid
    ls_req = 1; ls_write = 1; ls_addr = 32'h0080_0004; ls_wdata = 32'h1234_5678;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("write strobe", tlb_write, 1);
      check("write no read", tlb_read, 0);
      check("write wdata", tlb_wdata, 32'h1234_5678);
      check("write address", tlb_addr, 32'h0080_0004);
      tick();
    end
    tlb_valid = 1;
    tick();
    check("write ls_done", ls_done, 1);
    check("write ls_valid", ls_valid, 1);
    ls_req = 0; ls_write = 0; quiet_tlb();
    tick();

    // User access, both faults together: not_user wins
    is_user = 1; ls_req = 1; ls_addr = 32'h0000_0400;
    tick();
    check("user is_user", tlb_user, 1);
    tlb_nu = 1; tlb_np = 1;
    tick();
    check("fault ls_error", ls_error, 2);
    check("fault ls_done", ls_done, 1);
    check("fault ls_valid", ls_valid, 0);
    ls_req = 0; is_user = 0; quiet_tlb();
    tick();

    // Silent TLB
    if_req = 1; if_addr = 32'h0000_5000;
    tick();
    if (TO_EN) begin
      cnt = 1; seen = 0;
      while (!seen && cnt < 40) begin
        tick(); cnt++;
        seen = if_done;
      end
      check("timeout done seen", seen, 1);
      check("timeout cycle", cnt, 9);
      check("timeout code", if_error, 3);
      check("timeout no valid", if_valid, 0);
      if_req = 0;
      tick();
    end else begin
      seen = 0;
      for (int i = 0; i < 80; i++) begin
        tick();
        seen |= if_done;
      end
      check("no timeout done", seen, 0);
      check("still waiting", tlb_read, 1);
      tlb_valid = 1; tlb_rdata = 32'h0BAD_F00D;
      tick();
      check("late done", if_done, 1);
      check("late code", if_error, 0);
      if_req = 0; quiet_tlb();
      tick();
    end

    // Reset mid-access
    ls_req = 1; ls_addr = 32'h0000_7000;
    tick(); tick();
    check("busy before reset", tlb_read, 1);
    rst = 1;
    tick();
    check_quiet("mid-busy reset");
    rst = 0; ls_req = 0;
    tick();
    check("no done after reset", ls_done, 0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      is_user = 1'($urandom_range(0, 1));
      if (e_done[0]) begin
        if ($urandom_range(0, 9) < 8) if_req = 0;
      end else if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = $urandom;
        end
      end else if ($urandom_range(0, 49) == 0) begin
        if_req = 0;
      end
      if (e_done[1]) begin
        if ($urandom_range(0, 9) < 8) ls_req = 0;
      end else if (!ls_req) begin
        if ($urandom_range(0, 2) == 0) begin
          ls_req = 1; ls_addr = $urandom; ls_wdata = $urandom;
          ls_write = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 49) == 0) begin
        ls_req = 0;
      end
      if (m_active) begin
        tlb_valid = ($urandom_range(0, 3) == 0);
        tlb_np    = ($urandom_range(0, 11) == 0);
        tlb_nu    = ($urandom_range(0, 11) == 0);
        tlb_rdata = $urandom;
      end else begin
        quiet_tlb();
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
